// File: rtl/duck_move_control_if.sv
// Handshake bundle between the duck frame sequencer and the movement datapath.
interface duck_move_control_if;
   logic       key_left;
   logic       key_right;
   logic       key_up;
   logic       key_down;
   logic       draw_done;
   logic [7:0] bird_x;
   logic [6:0] bird_y;
   logic [3:0] control;
   logic       PorB;
   logic       frame_overrun;

   modport master (
      input  key_left, key_right, key_up, key_down, draw_done, bird_x, bird_y,
      output control, PorB, frame_overrun
   );

   modport slave (
      output key_left, key_right, key_up, key_down, draw_done, bird_x, bird_y,
      input  control, PorB, frame_overrun
   );
endinterface

// File: rtl/duck_move_control.sv
// Per-frame sequencer: erases, moves and redraws the player crosshair, then the
// bouncing bird, once per frame tick.
module duck_move_control #(
   parameter int unsigned FRAME_TICKS = 833334,
   parameter int unsigned X_MIN       = 2,
   parameter int unsigned X_MAX       = 158,
   parameter int unsigned Y_MIN       = 0,
   parameter int unsigned Y_MAX       = 117
) (
   input logic                 clk,
   input logic                 reset,
   duck_move_control_if.master bus
);

   localparam int unsigned     CNT_W    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);

   localparam logic [3:0] C_PREHOLD = 4'b0100;
   localparam logic [3:0] C_HOLD    = 4'b0000;
   localparam logic [3:0] C_CLEAR   = 4'b0001;
   localparam logic [3:0] C_LEFT    = 4'b0011;
   localparam logic [3:0] C_RIGHT   = 4'b0010;
   localparam logic [3:0] C_DOWN    = 4'b0110;
   localparam logic [3:0] C_UP      = 4'b0111;
   localparam logic [3:0] C_DRAW    = 4'b0101;

   // S_TURN is the player-to-bird turnaround; it shares the PREHOLD code.
   typedef enum logic [3:0] {
      S_PREHOLD, S_HOLD, S_CLEAR, S_LEFT, S_RIGHT, S_DOWN, S_UP, S_DRAW, S_TURN
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       control_q, control_d;
   logic             porb_q, porb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic             overrun_q, overrun_d;
   logic             dir_x_q, dir_x_d;
   logic             dir_y_q, dir_y_d;
   logic [3:0]       keys_q, keys_d;      // {left, right, down, up}
   logic             entry_q, entry_d;

   logic tick, hold_exit, done, dx_new, dy_new;
   logic eff_l, eff_r, eff_d, eff_u;

   // Opposing keys cancel each other.
   assign eff_l = keys_q[3] & ~keys_q[2];
   assign eff_r = keys_q[2] & ~keys_q[3];
   assign eff_d = keys_q[1] & ~keys_q[0];
   assign eff_u = keys_q[0] & ~keys_q[1];

   always_comb begin
      state_d   = state_q;
      porb_d    = porb_q;
      keys_d    = keys_q;
      dir_x_d   = dir_x_q;
      dir_y_d   = dir_y_q;
      hold_exit = 1'b0;

      tick  = (cnt_q == CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

      // The datapath's done flag is stale on the first cycle of CLEAR/DRAW.
      done   = bus.draw_done & ~entry_q;
      dx_new = dir_x_q ? ~(bus.bird_x >= 8'(X_MAX)) : (bus.bird_x <= 8'(X_MIN));
      dy_new = dir_y_q ? ~(bus.bird_y >= 7'(Y_MAX)) : (bus.bird_y <= 7'(Y_MIN));

      unique case (state_q)
         S_PREHOLD: begin
            state_d = S_HOLD;
            porb_d  = 1'b0;
         end
         S_HOLD: begin
            if (pending_q) begin
               hold_exit = 1'b1;
               keys_d    = {bus.key_left, bus.key_right, bus.key_down, bus.key_up};
               porb_d    = 1'b0;
               state_d   = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (done) begin
               if (porb_q) begin
                  dir_x_d = dx_new;
                  dir_y_d = dy_new;
                  state_d = dx_new ? S_RIGHT : S_LEFT;
               end else if (eff_l) state_d = S_LEFT;
               else if (eff_r)     state_d = S_RIGHT;
               else if (eff_d)     state_d = S_DOWN;
               else if (eff_u)     state_d = S_UP;
               else                state_d = S_DRAW;
            end
         end
         S_LEFT, S_RIGHT: begin
            if (porb_q)     state_d = dir_y_q ? S_DOWN : S_UP;
            else if (eff_d) state_d = S_DOWN;
            else if (eff_u) state_d = S_UP;
            else            state_d = S_DRAW;
         end
         S_DOWN, S_UP: state_d = S_DRAW;
         S_DRAW: begin
            if (done) begin
               state_d = porb_q ? S_PREHOLD : S_TURN;
               porb_d  = 1'b1;
            end
         end
         S_TURN:  state_d = S_CLEAR;
         default: state_d = S_PREHOLD;
      endcase

      // A tick landing on the HOLD exit edge re-arms pending without overrun.
      pending_d = hold_exit ? tick : (pending_q | tick);
      overrun_d = tick & pending_q & ~hold_exit;
      entry_d   = (state_d != state_q);

      unique case (state_d)
         S_HOLD:  control_d = C_HOLD;
         S_CLEAR: control_d = C_CLEAR;
         S_LEFT:  control_d = C_LEFT;
         S_RIGHT: control_d = C_RIGHT;
         S_DOWN:  control_d = C_DOWN;
         S_UP:    control_d = C_UP;
         S_DRAW:  control_d = C_DRAW;
         default: control_d = C_PREHOLD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_PREHOLD;
         control_q <= C_PREHOLD;
         porb_q    <= 1'b0;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         dir_x_q   <= 1'b1;
         dir_y_q   <= 1'b0;
         keys_q    <= '0;
         entry_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         control_q <= control_d;
         porb_q    <= porb_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         dir_x_q   <= dir_x_d;
         dir_y_q   <= dir_y_d;
         keys_q    <= keys_d;
         entry_q   <= entry_d;
      end
   end

   assign bus.control       = control_q;
   assign bus.PorB          = porb_q;
   assign bus.frame_overrun = overrun_q;

endmodule

// File: tb/tb_duck_move_control.sv
// Directed bench for duck_move_control: frame sequencing, key handling, bounce,
// draw-done pacing, overrun pulses and mid-frame reset.
module tb_duck_move_control;

   localparam int unsigned FT = 8;

   localparam logic [3:0] C_PRE = 4'b0100;
   localparam logic [3:0] C_HLD = 4'b0000;
   localparam logic [3:0] C_CLR = 4'b0001;
   localparam logic [3:0] C_LFT = 4'b0011;
   localparam logic [3:0] C_RGT = 4'b0010;
   localparam logic [3:0] C_DWN = 4'b0110;
   localparam logic [3:0] C_UP  = 4'b0111;
   localparam logic [3:0] C_DRW = 4'b0101;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   mode     = 0;    // 0: done 4 cycles after entry, 1: done always high, 2: done low
   logic [3:0] last_code;

   duck_move_control_if bus ();

   duck_move_control #(.FRAME_TICKS(FT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Wait for the next control code, check code/PorB, optionally its duration.
   task automatic expect_next(input string tag, input logic [3:0] code, input logic porb,
                              input int exp_len, input bit measure);
      int n = 0;
      int len;
      logic [3:0] c;
      while (bus.control === last_code && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $error("FAIL %s_wait observed=timeout expected=state change", tag);
      end
      c = bus.control;
      last_code = c;
      chk({tag, "_code"}, int'(c), int'(code));
      chk({tag, "_porb"}, int'(bus.PorB), int'(porb));
      if (measure) begin
         len = 1;
         step();
         while (bus.control === c && len < 100) begin
            len++;
            step();
         end
         if (exp_len != 0) chk({tag, "_len"}, len, exp_len);
      end
   endtask

   task automatic bird_phase(input string tag, input logic [3:0] h, input logic [3:0] v,
                             input int dlen);
      expect_next({tag, "_turn"}, C_PRE, 1'b1, 1, 1'b1);
      expect_next({tag, "_clrB"}, C_CLR, 1'b1, dlen, 1'b1);
      expect_next({tag, "_horB"}, h, 1'b1, 1, 1'b1);
      expect_next({tag, "_verB"}, v, 1'b1, 1, 1'b1);
      expect_next({tag, "_drwB"}, C_DRW, 1'b1, dlen, 1'b1);
      expect_next({tag, "_pre"}, C_PRE, 1'b1, 1, 1'b1);
      expect_next({tag, "_hold"}, C_HLD, 1'b0, 0, 1'b1);
   endtask

   // Datapath model: raises draw_done according to mode.
   initial begin
      int cnt = 0;
      logic [3:0] lc = 4'hf;
      bus.draw_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.control !== lc) cnt = 0;
         else cnt++;
         lc = bus.control;
         case (mode)
            1:       bus.draw_done = 1'b1;
            2:       bus.draw_done = 1'b0;
            default: bus.draw_done = ((lc == C_CLR) || (lc == C_DRW)) && (cnt >= 4);
         endcase
      end
   end

   initial begin
      int n;
      int ovr;
      int bad;
      reset         = 1'b1;
      bus.key_left  = 1'b0;
      bus.key_right = 1'b0;
      bus.key_up    = 1'b0;
      bus.key_down  = 1'b0;
      bus.bird_x    = 8'd80;
      bus.bird_y    = 7'd50;

      step();
      step();
      chk("rst_control", int'(bus.control), int'(C_PRE));
      chk("rst_porb", int'(bus.PorB), 0);
      chk("rst_overrun", int'(bus.frame_overrun), 0);
      reset = 1'b0;
      last_code = C_PRE;

      // Frame 1: no keys, bird moves right/up.
      expect_next("f1_hold", C_HLD, 1'b0, 8, 1'b1);
      expect_next("f1_clrP", C_CLR, 1'b0, 5, 1'b1);
      expect_next("f1_drwP", C_DRW, 1'b0, 5, 1'b1);
      bus.key_left = 1'b1;
      bus.key_up   = 1'b1;
      bird_phase("f1", C_RGT, C_UP, 5);

      // Frame 2: left+up snapshot, released mid-frame.
      expect_next("f2_clrP", C_CLR, 1'b0, 5, 1'b1);
      bus.key_left = 1'b0;
      bus.key_up   = 1'b0;
      expect_next("f2_left", C_LFT, 1'b0, 1, 1'b1);
      expect_next("f2_up", C_UP, 1'b0, 1, 1'b1);
      expect_next("f2_drwP", C_DRW, 1'b0, 5, 1'b1);
      bus.key_left  = 1'b1;
      bus.key_right = 1'b1;
      bird_phase("f2", C_RGT, C_UP, 5);

      // Frame 3: left+right cancel; bird hits right/top limits.
      expect_next("f3_clrP", C_CLR, 1'b0, 5, 1'b1);
      expect_next("f3_drwP", C_DRW, 1'b0, 5, 1'b1);
      bus.key_left  = 1'b0;
      bus.key_right = 1'b0;
      bus.bird_x    = 8'd158;
      bus.bird_y    = 7'd0;
      bird_phase("f3", C_LFT, C_DWN, 5);

      // Frame 4: directions persist away from the limits.
      bus.bird_x = 8'd80;
      bus.bird_y = 7'd50;
      expect_next("f4_clrP", C_CLR, 1'b0, 5, 1'b1);
      expect_next("f4_drwP", C_DRW, 1'b0, 5, 1'b1);
      bird_phase("f4", C_LFT, C_DWN, 5);

      // Frame 5: draw_done held high, CLEAR/DRAW last two cycles.
      mode = 1;
      expect_next("f5_clrP", C_CLR, 1'b0, 2, 1'b1);
      expect_next("f5_drwP", C_DRW, 1'b0, 2, 1'b1);
      bird_phase("f5", C_LFT, C_DWN, 2);

      // Frame 6: draw_done stuck low, ticks keep arriving.
      mode = 2;
      n = 0;
      while (bus.frame_overrun !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("f6_first_overrun", int'(bus.frame_overrun), 1);
      ovr = 0;
      bad = 0;
      for (int i = 0; i < 24; i++) begin
         step();
         if (bus.frame_overrun === 1'b1) ovr++;
         if (bus.control !== C_CLR) bad++;
      end
      chk("f6_overrun_pulses", ovr, 3);
      chk("f6_stuck_in_clear", bad, 0);
      mode = 0;
      expect_next("f6_clrP", C_CLR, 1'b0, 0, 1'b1);
      expect_next("f6_drwP", C_DRW, 1'b0, 5, 1'b1);
      bird_phase("f6", C_LFT, C_DWN, 5);

      // Frame 7: reset one cycle into DRAW(B).
      expect_next("f7_clrP", C_CLR, 1'b0, 5, 1'b1);
      expect_next("f7_drwP", C_DRW, 1'b0, 5, 1'b1);
      expect_next("f7_turn", C_PRE, 1'b1, 1, 1'b1);
      expect_next("f7_clrB", C_CLR, 1'b1, 5, 1'b1);
      expect_next("f7_horB", C_LFT, 1'b1, 1, 1'b1);
      expect_next("f7_verB", C_DWN, 1'b1, 1, 1'b1);
      expect_next("f7_drwB", C_DRW, 1'b1, 0, 1'b0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_control", int'(bus.control), int'(C_PRE));
      chk("mid_rst_porb", int'(bus.PorB), 0);
      chk("mid_rst_overrun", int'(bus.frame_overrun), 0);
      last_code = C_PRE;

      // Frame 8: fresh tick required; directions back to right/up.
      expect_next("f8_hold", C_HLD, 1'b0, 8, 1'b1);
      expect_next("f8_clrP", C_CLR, 1'b0, 5, 1'b1);
      expect_next("f8_drwP", C_DRW, 1'b0, 5, 1'b1);
      bird_phase("f8", C_RGT, C_UP, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
